// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, exception causes,
// ALU control encodings and EX/MEM stage FSM states.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [4:0] CAUSE_NONE = 5'd0;
    localparam logic [4:0] CAUSE_OV   = 5'd12;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_MUL = 4'b1000
    } alu_ctrl_t;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_EXC = 1'b1
    } exmem_state_t;

endpackage

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution and a precise
// overflow exception that stays pending until trap logic acks it.
module ex_mem_stage #(
    parameter int         DATA_W   = 32,
    parameter int         REG_AW   = 5,
    parameter logic [4:0] CAUSE_OV = 5'd12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              zero,
    input  logic              overflow,
    input  logic              ovf_trap_en,
    input  logic              reg_write_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              mem_to_reg_in,
    input  logic              branch_in,
    input  logic [DATA_W-1:0] branch_target_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [REG_AW-1:0] write_reg_in,
    input  logic              exc_ack,
    output logic              out_valid,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] store_data,
    output logic [REG_AW-1:0] write_reg,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              pc_src,
    output logic [DATA_W-1:0] branch_target,
    output logic              exc_req,
    output logic [DATA_W-1:0] epc,
    output logic [4:0]        cause
);
    import mips_pkg::*;

    exmem_state_t r_state;
    exmem_state_t w_state_nxt;
    logic         w_trap;
    logic         w_hold;
    logic         w_slot_ok;
    logic         w_take_exc;
    logic         w_clr_exc;

    assign w_trap = in_valid & overflow & ovf_trap_en;

    // Stall only freezes the stage in RUN; in EXC bubbles keep flowing.
    always_comb begin
        w_state_nxt = r_state;
        w_hold      = 1'b0;
        w_slot_ok   = 1'b0;
        w_take_exc  = 1'b0;
        w_clr_exc   = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (stall) begin
                    w_hold = 1'b1;
                end else if (flush || !in_valid) begin
                    w_slot_ok = 1'b0;
                end else if (w_trap) begin
                    w_take_exc  = 1'b1;
                    w_state_nxt = ST_EXC;
                end else begin
                    w_slot_ok = 1'b1;
                end
            end
            ST_EXC: begin
                if (exc_ack) begin
                    w_clr_exc   = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_RUN;
            out_valid     <= 1'b0;
            alu_result    <= '0;
            store_data    <= '0;
            write_reg     <= '0;
            reg_write     <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_to_reg    <= 1'b0;
            pc_src        <= 1'b0;
            branch_target <= '0;
            exc_req       <= 1'b0;
            epc           <= '0;
            cause         <= CAUSE_NONE;
        end else begin
            r_state <= w_state_nxt;
            if (!w_hold) begin
                alu_result    <= alu_out;
                store_data    <= store_data_in;
                write_reg     <= write_reg_in;
                branch_target <= branch_target_in;
                out_valid     <= w_slot_ok;
                reg_write     <= w_slot_ok & reg_write_in;
                mem_read      <= w_slot_ok & mem_read_in;
                mem_write     <= w_slot_ok & mem_write_in;
                mem_to_reg    <= w_slot_ok & mem_to_reg_in;
                pc_src        <= w_slot_ok & branch_in & zero;
            end
            if (w_take_exc) begin
                exc_req <= 1'b1;
                epc     <= pc_in;
                cause   <= CAUSE_OV;
            end else if (w_clr_exc) begin
                exc_req <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline register between the EX stage (ALU_Cal) and the MEM stage.
- Captures ALU_out, Zero and overflow plus the forwarded control and data.
- Resolves conditional branches and converts arithmetic overflow into a precise exception request.
- Holds an exception-pending state until the trap logic acknowledges it.

Parameters:
DATA_W, 32, datapath width (ALU result, store data, PC)
REG_AW, 5, register-file address width
CAUSE_OV, 5'd12, cause code reported for arithmetic overflow

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
stall  in  1  hold all stage registers (MEM busy)
flush  in  1  squash the incoming slot (bubble)
in_valid  in  1  EX slot holds a real instruction
alu_out  in  DATA_W  ALU result
zero  in  1  ALU zero flag
overflow  in  1  ALU overflow flag
ovf_trap_en  in  1  instruction traps on overflow (add/addi/sub; not addu/subu)
reg_write_in  in  1  control: write register file
mem_read_in  in  1  control: load
mem_write_in  in  1  control: store
mem_to_reg_in  in  1  control: writeback select
branch_in  in  1  control: beq
branch_target_in  in  DATA_W  computed branch target
pc_in  in  DATA_W  PC of the EX instruction
store_data_in  in  DATA_W  rt value for sw
write_reg_in  in  REG_AW  destination register
exc_ack  in  1  trap logic accepted the exception
out_valid  out  1  MEM slot valid
alu_result  out  DATA_W  registered alu_out
store_data  out  DATA_W  registered store data
write_reg  out  REG_AW  registered destination
reg_write, mem_read, mem_write, mem_to_reg  out  1 each  registered, qualified controls
pc_src  out  1  branch taken, registered
branch_target  out  DATA_W  registered target
exc_req  out  1  exception pending
epc  out  DATA_W  PC of the faulting instruction
cause  out  5  exception cause

Behaviour:
- Reset (rst low, asynchronous): every output is 0, and the FSM is in RUN.
- Latency is one cycle. The inputs sampled at edge N appear on the outputs after edge N.
- Trap condition: trap = in_valid & overflow & ovf_trap_en.
- FSM RUN, no stall:
  - If flush or !in_valid: out_valid=0, all write/read/branch controls 0, and the data registers are loaded anyway (don't-care).
  - Else if trap: out_valid=0, reg_write=mem_write=mem_read=pc_src=0, epc<=pc_in, cause<=CAUSE_OV, exc_req<=1, go to EXC.
  - Else: load all fields, with pc_src <= branch_in & zero.
- FSM EXC:
  - exc_req stays 1, and epc and cause are held.
  - Every cycle inserts a bubble: out_valid=0, controls 0.
  - When exc_ack=1: exc_req<=0, go to RUN. The same edge inserts a bubble; the EX instruction in flight is discarded.
- Stall (RUN): all registers hold, including pc_src; no new trap is taken.
- Stall in EXC: ignored. Bubbles continue and exc_ack is still honoured.
- Priority in RUN: stall > flush > trap > normal.
- flush and trap in the same cycle: flush wins, so no exception is raised.
- pc_src is a single-cycle pulse per taken branch.
- pc_src is cleared on the next non-stalled edge unless another taken branch is loaded.
- Overflow with ovf_trap_en=0 (addu) passes through as a normal result with no exception.
- exc_ack while in RUN has no effect.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W and REG_AW
  - the cause codes CAUSE_OV and CAUSE_NONE
  - the ALUControl encodings (ADD 0010, SUB 0110, MUL 1000, AND 0000, OR 0001, SLT 0111)
  - the FSM state encoding ST_RUN/ST_EXC
- No sub-module; the stage is a single flat register/FSM block.

Test Plan:
- Reset: hold rst=0 with random inputs, then release → all outputs 0. Next edge with add, alu_out=32'h0000_0005, reg_write_in=1, write_reg_in=8 → alu_result=5, reg_write=1, write_reg=8, out_valid=1.
- Branch: branch_in=1 with zero=1 and branch_target_in=32'h0040_0020 → pc_src=1 with target 0x00400020 for exactly one cycle. Repeat with zero=0 → pc_src=0.
- Overflow trap: ovf_trap_en=1, overflow=1, pc_in=32'h0040_0010, reg_write_in=1 →
  - exc_req=1, epc=0x00400010, cause=12, reg_write=0, out_valid=0
  - Hold 3 cycles, then exc_ack=1 → exc_req=0 the next cycle.
- addu overflow: overflow=1, ovf_trap_en=0, alu_out=32'h8000_0000 → alu_result=0x80000000, reg_write=1, exc_req=0.
- Stall/flush: stall=1 for 2 cycles with changing inputs → outputs frozen. flush=1 together with a trap condition → out_valid=0 and exc_req=0.
- Reset mid-exception: while in EXC assert rst=0 asynchronously between edges → exc_req, epc and cause go to 0 immediately. After release, the FSM is in RUN.
